// File: rtl/ball_motion_ctl.sv
// Per-frame ball motion controller: advances the ball centre at vblank start,
// bounces it off walls, paddle and bricks, and sequences serve/lost/game-over.
module ball_motion_ctl #(
  parameter int H_RES    = 800,
  parameter int V_RES    = 600,
  parameter int BALL_R   = 10,
  parameter int SPEED    = 2,
  parameter int PADDLE_Y = 560,
  parameter int PADDLE_W = 100,
  parameter int LIVES    = 3
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        vblnk_in,
  input  logic [10:0] paddle_x,
  input  logic        launch,
  input  logic        brick_hit,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic        ball_en,
  output logic        ball_lost,
  output logic [2:0]  lives,
  output logic        game_over
);

  typedef enum logic [1:0] {STICK, MOVE, LOST, OVER} state_e;

  localparam logic [10:0]        SERVE_DX   = 11'(PADDLE_W / 2);
  localparam logic [10:0]        SERVE_Y    = 11'(PADDLE_Y - BALL_R);
  localparam logic [10:0]        X_RIGHT    = 11'(H_RES - 1 - BALL_R);
  localparam logic [10:0]        Y_TOP      = 11'(BALL_R);
  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
  localparam logic signed [12:0] SPD        = 13'(SPEED);
  localparam logic signed [12:0] RAD        = 13'(BALL_R);
  localparam logic signed [12:0] VRES       = 13'(V_RES);
  localparam logic signed [12:0] PADY       = 13'(PADDLE_Y);
  localparam logic signed [12:0] PADW       = 13'(PADDLE_W);
  localparam logic signed [12:0] XMAX       = 13'(H_RES - 1);

  state_e      state_q, state_d;
  logic        vblnk_q;
  logic [10:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic        dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic        hit_pend_q, hit_pend_d;
  logic [2:0]  lives_q, lives_d;
  logic        ball_lost_q, ball_lost_d;
  logic        ball_en_q, ball_en_d;
  logic        game_over_q, game_over_d;

  logic              tick;
  logic signed [12:0] nx, ny, px;
  logic              paddle_hit, bottom;

  always_comb begin
    tick = vblnk_in & ~vblnk_q;
    nx   = $signed({2'b00, ball_x_q}) + (dx_neg_q ? -SPD : SPD);
    ny   = $signed({2'b00, ball_y_q}) + (dy_neg_q ? -SPD : SPD);
    px   = $signed({2'b00, paddle_x});
    paddle_hit = ~dy_neg_q && (ny + RAD >= PADY) && (nx >= px) && (nx <= px + PADW);
    bottom     = (ny + RAD >= VRES) && !paddle_hit;

    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dx_neg_d    = dx_neg_q;
    dy_neg_d    = dy_neg_q;
    lives_d     = lives_q;
    ball_lost_d = 1'b0;
    hit_pend_d  = hit_pend_q | brick_hit;

    if (tick) begin
      // a hit arriving on the update cycle itself is held for the next frame
      hit_pend_d = brick_hit;
      unique case (state_q)
        STICK: begin
          ball_x_d = paddle_x + SERVE_DX;
          ball_y_d = SERVE_Y;
          if (launch) begin
            state_d  = MOVE;
            dx_neg_d = 1'b0;
            dy_neg_d = 1'b1;
          end
        end
        MOVE: begin
          if (bottom) begin
            state_d     = LOST;
            ball_lost_d = 1'b1;
            lives_d     = (lives_q != '0) ? lives_q - 3'd1 : '0;
          end else begin
            if (paddle_hit) begin
              ball_y_d = SERVE_Y;
              dy_neg_d = 1'b1;
            end else begin
              dy_neg_d = dy_neg_q ^ hit_pend_q;
              ball_y_d = 11'(ny);
              if (ny - RAD < 13'sd0) begin
                ball_y_d = Y_TOP;
                dy_neg_d = 1'b0;
              end
            end
            if (nx - RAD < 13'sd0) begin
              ball_x_d = Y_TOP;
              dx_neg_d = 1'b0;
            end else if (nx + RAD > XMAX) begin
              ball_x_d = X_RIGHT;
              dx_neg_d = 1'b1;
            end else begin
              ball_x_d = 11'(nx);
            end
          end
        end
        LOST: begin
          if (lives_q != '0) begin
            state_d  = STICK;
            ball_x_d = paddle_x + SERVE_DX;
            ball_y_d = SERVE_Y;
          end else begin
            state_d = OVER;
          end
        end
        OVER: begin
          if (launch) begin
            state_d  = STICK;
            lives_d  = LIVES_INIT;
            ball_x_d = paddle_x + SERVE_DX;
            ball_y_d = SERVE_Y;
          end
        end
        default: state_d = STICK;
      endcase
    end

    ball_en_d   = (state_d == STICK) || (state_d == MOVE);
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state_q     <= STICK;
      vblnk_q     <= 1'b0;
      ball_x_q    <= SERVE_DX;
      ball_y_q    <= SERVE_Y;
      dx_neg_q    <= 1'b0;
      dy_neg_q    <= 1'b1;
      hit_pend_q  <= 1'b0;
      lives_q     <= LIVES_INIT;
      ball_lost_q <= 1'b0;
      ball_en_q   <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vblnk_q     <= vblnk_in;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dx_neg_q    <= dx_neg_d;
      dy_neg_q    <= dy_neg_d;
      hit_pend_q  <= hit_pend_d;
      lives_q     <= lives_d;
      ball_lost_q <= ball_lost_d;
      ball_en_q   <= ball_en_d;
      game_over_q <= game_over_d;
    end
  end

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign ball_en   = ball_en_q;
  assign ball_lost = ball_lost_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;

endmodule
